// File: rtl/mem_stage_mmio.sv
// MIPS MEM stage: handshaked accept, variable-latency RAM or serial MMIO access,
// misalign/timeout detection, and load extension / bypass result for writeback.
module mem_stage_mmio #(
  parameter int unsigned    ADDR_W    = 32,
  parameter logic [31:0]    MMIO_BASE = 32'hFFFF0000,
  parameter int unsigned    TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        bundle_in,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [31:0]       store_data_in,
  input  logic [4:0]        write_reg_in,
  input  logic [31:0]       pc_seq_in,
  output logic              out_valid,
  output logic [31:0]       result_out,
  output logic [4:0]        write_reg_out,
  output logic [1:0]        wb_ctrl_out,
  output logic [31:0]       pc_seq_out,
  output logic              misalign_out,
  output logic              timeout_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic [7:0]        serial_in,
  input  logic              serial_valid_in,
  input  logic              serial_ready_in,
  output logic [7:0]        serial_out,
  output logic              serial_rden_out,
  output logic              serial_wren_out
);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, SER_WAIT, DONE} state_t;

  localparam logic [ADDR_W-1:0] MMIO_A = MMIO_BASE[ADDR_W-1:0];
  localparam logic [15:0]       TO_M1  = 16'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        bundle_q, bundle_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       sdata_q, sdata_d;
  logic [4:0]        wreg_q, wreg_d;
  logic [31:0]       pc_q, pc_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [31:0]       result_q, result_d;
  logic              misalign_q, misalign_d;
  logic              timeout_q, timeout_d;

  logic        in_access, in_mis, in_mmio, st_wr, ser_go;
  logic [31:0] lane, load_val;

  // Write beats read; a bypassed read never touches memory.
  assign in_access = bundle_in[3] | (bundle_in[2] & ~bundle_in[7]);
  assign in_mis    = in_access & (((bundle_in[5:4] == 2'b01) & address_in[0]) |
                                  (bundle_in[5] & (|address_in[1:0])));
  assign in_mmio   = address_in[ADDR_W-1:2] == MMIO_A[ADDR_W-1:2];

  assign st_wr  = bundle_q[3];
  assign ser_go = st_wr ? serial_ready_in : serial_valid_in;
  assign lane   = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_val = lane;
    case (bundle_q[5:4])
      2'b00:   load_val = {{24{lane[7]  & bundle_q[6]}}, lane[7:0]};
      2'b01:   load_val = {{16{lane[15] & bundle_q[6]}}, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    bundle_d   = bundle_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    wreg_d     = wreg_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    misalign_d = misalign_q;
    timeout_d  = timeout_q;
    case (state_q)
      IDLE: if (in_valid) begin
        bundle_d   = bundle_in;
        addr_d     = address_in;
        sdata_d    = store_data_in;
        wreg_d     = write_reg_in;
        pc_d       = pc_seq_in;
        cnt_d      = '0;
        result_d   = 32'(address_in);
        misalign_d = in_mis;
        timeout_d  = 1'b0;
        if (!in_access || in_mis) state_d = DONE;
        else if (in_mmio)         state_d = SER_WAIT;
        else                      state_d = MEM_WAIT;
      end
      MEM_WAIT, SER_WAIT: begin
        // Completion is tested before the timeout so a last-cycle ack still wins.
        if ((state_q == MEM_WAIT) ? mem_ack : ser_go) begin
          if (!st_wr && !bundle_q[7])
            result_d = (state_q == MEM_WAIT) ? load_val : {24'b0, serial_in};
          state_d = DONE;
        end else if (cnt_q == TO_M1) begin
          timeout_d = 1'b1;
          result_d  = '0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      bundle_q   <= '0;
      addr_q     <= '0;
      sdata_q    <= '0;
      wreg_q     <= '0;
      pc_q       <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bundle_q   <= bundle_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      wreg_q     <= wreg_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign mem_req   = state_q == MEM_WAIT;
  assign mem_we    = mem_req & st_wr;
  assign mem_addr  = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;

  always_comb begin
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    if (mem_req) begin
      case (bundle_q[5:4])
        2'b00: begin
          mem_be    = 4'b0001 << addr_q[1:0];
          mem_wdata = {4{sdata_q[7:0]}};
        end
        2'b01: begin
          mem_be    = 4'b0011 << addr_q[1:0];
          mem_wdata = {2{sdata_q[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = sdata_q;
        end
      endcase
    end
  end

  assign serial_rden_out = (state_q == SER_WAIT) & ~st_wr & bundle_q[2] & serial_valid_in;
  assign serial_wren_out = (state_q == SER_WAIT) & st_wr & serial_ready_in;
  assign serial_out      = serial_wren_out ? sdata_q[7:0] : 8'h00;

  assign misalign_out  = out_valid & misalign_q;
  assign timeout_out   = out_valid & timeout_q;
  assign write_reg_out = (misalign_q | timeout_q) ? 5'd0 : wreg_q;
  assign wb_ctrl_out   = bundle_q[1:0];
  assign pc_seq_out    = pc_q;
  assign result_out    = result_q;

endmodule
